mem_stage_be: RTL and testbench
===============================

MEM_STAGE_BE -- requirements
Module: mem_stage_be

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath/address width; must be a multiple of 32.
REQ-002 SHALL have parameter BYTE_SWAP, default 1, meaning 1 = memory bus is byte-reversed (little-endian core to big-endian bus), 0 = pass-through.
REQ-003 SHALL have ports, in this order:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
memory_stall  in  1  external pipeline freeze
ALU_result_3  in  XLEN  effective address / ALU result
writedata_3  in  XLEN  store data (rs2)
WriteBack_3  in  1  register write enable
Mem_3  in  2  bit1 load, bit0 store; 00 none; 11 illegal, treated as none
Funct3_3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
Rd_3  in  5  destination register
D_readData  in  XLEN  memory read data
D_ready  in  1  memory completes the current request this cycle
D_addr  out  XLEN-2  word address
D_ren  out  1  read request
D_wen  out  1  write request
D_writeData  out  XLEN  lane-aligned store data
D_byteEn  out  XLEN/8  byte write enables
mem_busy  out  1  stall request to earlier stages
memory_result_4  out  XLEN  extended load data
ALU_result_4  out  XLEN  registered ALU result
Rd_4  out  5  registered destination
WriteBack_4  out  1  registered write enable
Mem2Reg  out  1  registered "result comes from memory"
misalign_4  out  1  registered misaligned-access flag (present only with MISALIGN_TRAP_EN)

Function
REQ-004 SHALL implement a two-state FSM, IDLE and WAIT, for the memory handshake.
REQ-005 In IDLE with a load or store: SHALL drive D_ren/D_wen, D_addr, D_writeData and D_byteEn combinationally from the stage-3 inputs.
REQ-006 In IDLE, if D_ready=1 in the same cycle, the access SHALL complete with zero wait states and the FSM SHALL stay in IDLE.
REQ-007 In IDLE with an access and D_ready=0: SHALL latch address, store data, byte enables, Funct3, Rd, WriteBack and Mem into holding registers, then move to WAIT.
REQ-008 In WAIT: SHALL drive the request from the holding registers, ignoring the stage-3 inputs, and SHALL stay in WAIT until D_ready=1, then return to IDLE.
REQ-009 mem_busy SHALL equal (access in progress) AND NOT D_ready, where "access in progress" is an IDLE-state access or the WAIT state; mem_busy is combinational.
REQ-010 Stage-4 registers SHALL load only when memory_stall=0 and mem_busy=0; otherwise they hold their value.
REQ-011 memory_stall=1 while in WAIT SHALL NOT cancel the request; completion data SHALL be held in the holding registers until the freeze releases.
REQ-012 Load path: SHALL byte-swap D_readData when BYTE_SWAP=1, shift it right by 8*addr[1:0], then sign-extend (B, H) or zero-extend (BU, HU); W passes through unchanged.
REQ-013 Store path: SHALL replicate the low byte (SB) or low halfword (SH) into every lane; D_byteEn SHALL be 0001<<off for SB, 0011<<off for SH and 1111 for SW.
REQ-014 With BYTE_SWAP=1, SHALL byte-reverse both D_writeData and D_byteEn.
REQ-015 With no access, D_ren, D_wen and D_byteEn SHALL be 0.
REQ-016 Mem2Reg SHALL register Mem bit1; memory_result_4 SHALL register the extended load data (REQ-012).
REQ-017 Load-to-writeback latency SHALL be one cycle after D_ready=1 when memory_stall=0.

Reset
REQ-018 When rst_n=0 at a clock edge: the FSM SHALL go to IDLE and every stage-4 output, holding register and misalign_4 SHALL clear to 0.
REQ-019 Reset SHALL abort any access in WAIT: D_ren and D_wen SHALL be 0 in the first cycle after reset.

Configuration
REQ-020 Macro MISALIGN_TRAP_EN, when defined:
- a misaligned H/HU/SH access (odd address) or W/SW access (addr[1:0]≠0) SHALL issue no D_ren/D_wen;
- it SHALL register misalign_4=1 and force WriteBack_4=0 and Mem2Reg=0;
- mem_busy SHALL stay 0 for that access.
REQ-021 When MISALIGN_TRAP_EN is undefined: misalign_4 SHALL be absent, the low offset bits SHALL be masked to the natural alignment of the access, and the access proceeds.

Structure
REQ-022 A shared package SHALL hold the Funct3 encodings, the Mem bit positions and the FSM state enum.
REQ-023 The load extract/extend logic SHALL be one sub-module, load_align, parametrised by XLEN.

Verification
REQ-024 LW at 0x100, D_ready=1 immediately, bus data 0x78563412 -> memory_result_4=0x12345678 next cycle, mem_busy never 1.
REQ-025 LB at 0x103, bus byte lane value 0x80, D_ready after 3 cycles -> mem_busy=1 for 3 cycles, memory_result_4=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-026 SH 0xBEEF at 0x202 -> D_byteEn=0011 after swap, D_writeData=0xEFBEEFBE, D_wen for exactly the acknowledged cycle(s).
REQ-027 In WAIT, toggle ALU_result_3 and assert memory_stall across the D_ready edge -> D_addr constant; result appears only after memory_stall falls.
REQ-028 Assert rst_n=0 during WAIT -> D_ren=0 next cycle, all outputs 0, FSM in IDLE.
REQ-029 With MISALIGN_TRAP_EN, LW at 0x101 -> D_ren=0, misalign_4=1, WriteBack_4=0; without the macro -> D_addr=0x40 and the load completes.

Source files
------------

// File: rtl/mem_stage_be_pkg.sv
// Shared encodings for the big-endian memory stage: Funct3 sizes, Mem bit
// positions, handshake FSM states and offset alignment helpers.
package mem_stage_be_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int MEM_LD = 1;
    localparam int MEM_ST = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // Byte offset forced to the natural alignment of the access size.
    function automatic logic [1:0] align_off(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return off;
            2'b01:   return {off[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        return align_off(f3, off) != off;
    endfunction

endpackage

// File: rtl/mem_stage_be_load_align.sv
// load_align: optional bus byte reversal, lane extraction by byte offset and
// sign/zero extension of B/H loads; W returns the (swapped) bus word unchanged.
module load_align
    import mem_stage_be_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BYTE_SWAP = 1
) (
    input  logic [XLEN-1:0] raw_data,
    input  logic [1:0]      off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] ld_data
);

    logic [XLEN-1:0] lane;
    logic [15:0]     low16;

    always_comb begin
        lane = raw_data;
        if (BYTE_SWAP != 0) begin
            for (int i = 0; i < XLEN / 8; i++)
                lane[8*i +: 8] = raw_data[XLEN-8-8*i +: 8];
        end
        low16 = 16'(lane >> {off, 3'b000});
        case (funct3)
            F3_B:    ld_data = {{(XLEN-8){low16[7]}}, low16[7:0]};
            F3_H:    ld_data = {{(XLEN-16){low16[15]}}, low16};
            F3_BU:   ld_data = {{(XLEN-8){1'b0}}, low16[7:0]};
            F3_HU:   ld_data = {{(XLEN-16){1'b0}}, low16};
            default: ld_data = lane;
        endcase
    end

endmodule

// File: rtl/mem_stage_be.sv
// Memory stage with IDLE/WAIT handshake towards a byte-reversed data bus.
// Define MISALIGN_TRAP_EN to trap misaligned accesses instead of masking offsets.
module mem_stage_be
    import mem_stage_be_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BYTE_SWAP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              memory_stall,
    input  logic [XLEN-1:0]   ALU_result_3,
    input  logic [XLEN-1:0]   writedata_3,
    input  logic              WriteBack_3,
    input  logic [1:0]        Mem_3,
    input  logic [2:0]        Funct3_3,
    input  logic [4:0]        Rd_3,
    input  logic [XLEN-1:0]   D_readData,
    input  logic              D_ready,
    output logic [XLEN-3:0]   D_addr,
    output logic              D_ren,
    output logic              D_wen,
    output logic [XLEN-1:0]   D_writeData,
    output logic [XLEN/8-1:0] D_byteEn,
    output logic              mem_busy,
    output logic [XLEN-1:0]   memory_result_4,
    output logic [XLEN-1:0]   ALU_result_4,
    output logic [4:0]        Rd_4,
    output logic              WriteBack_4,
    output logic              Mem2Reg
`ifdef MISALIGN_TRAP_EN
    ,
    output logic              misalign_4
`endif
);

    localparam int NB = XLEN / 8;

    function automatic logic [XLEN-1:0] swap_data(input logic [XLEN-1:0] x);
        logic [XLEN-1:0] r;
        r = x;
        if (BYTE_SWAP != 0) begin
            for (int i = 0; i < NB; i++) r[8*i +: 8] = x[XLEN-8-8*i +: 8];
        end
        return r;
    endfunction

    function automatic logic [NB-1:0] swap_be(input logic [NB-1:0] x);
        logic [NB-1:0] r;
        r = x;
        if (BYTE_SWAP != 0) begin
            for (int i = 0; i < NB; i++) r[i] = x[NB-1-i];
        end
        return r;
    endfunction

    state_e          state_q, state_d;
    logic            done_q, done_d;
    logic [XLEN-1:0] hold_addr_q, hold_addr_d;
    logic [XLEN-1:0] hold_wdata_q, hold_wdata_d;
    logic [XLEN-1:0] hold_rdata_q, hold_rdata_d;
    logic [NB-1:0]   hold_be_q, hold_be_d;
    logic [2:0]      hold_f3_q, hold_f3_d;
    logic [4:0]      hold_rd_q, hold_rd_d;
    logic            hold_wb_q, hold_wb_d;
    logic [1:0]      hold_mem_q, hold_mem_d;
    logic [1:0]      hold_off_q, hold_off_d;

    logic [XLEN-1:0] res_q, res_d;
    logic [XLEN-1:0] alu4_q, alu4_d;
    logic [4:0]      rd4_q, rd4_d;
    logic            wb4_q, wb4_d;
    logic            m2r_q, m2r_d;
`ifdef MISALIGN_TRAP_EN
    logic            mis4_q, mis4_d;
`endif

    logic [1:0]      mem3, off3;
    logic            is_ld3, is_st3, acc3, mis3, req3;
    logic            in_wait, use_hold, active, complete, busy, adv;
    logic [XLEN-1:0] wd3;
    logic [NB-1:0]   be3;

    always_comb begin : decode
        mem3     = (Mem_3 == 2'b11) ? 2'b00 : Mem_3;
        is_ld3   = mem3[MEM_LD];
        is_st3   = mem3[MEM_ST];
        acc3     = is_ld3 | is_st3;
        off3     = align_off(Funct3_3, ALU_result_3[1:0]);
`ifdef MISALIGN_TRAP_EN
        mis3     = acc3 & misaligned(Funct3_3, ALU_result_3[1:0]);
`else
        mis3     = 1'b0;
`endif
        in_wait  = (state_q == ST_WAIT);
        // done_q marks a finished access whose result waits out a freeze;
        // stage 3 still holds that instruction and must not reissue it.
        use_hold = in_wait | done_q;
        req3     = ~use_hold & acc3 & ~mis3;
        active   = in_wait | req3;
        busy     = active & ~D_ready;
        complete = active & D_ready;
        adv      = ~memory_stall & ~busy;
    end

    always_comb begin : store_lanes
        wd3 = '0;
        be3 = '0;
        case (Funct3_3[1:0])
            2'b00: begin
                wd3 = {NB{writedata_3[7:0]}};
                be3 = NB'(1) << off3;
            end
            2'b01: begin
                wd3 = {(NB/2){writedata_3[15:0]}};
                be3 = NB'(3) << off3;
            end
            default: begin
                wd3 = {(NB/4){writedata_3[31:0]}};
                be3 = NB'(15);
            end
        endcase
        wd3 = (req3 & is_st3) ? swap_data(wd3) : '0;
        be3 = req3 ? swap_be(be3) : '0;
    end

    always_comb begin : bus
        D_ren       = 1'b0;
        D_wen       = 1'b0;
        D_addr      = ALU_result_3[XLEN-1:2];
        D_writeData = wd3;
        D_byteEn    = be3;
        if (in_wait) begin
            D_ren       = hold_mem_q[MEM_LD];
            D_wen       = hold_mem_q[MEM_ST];
            D_addr      = hold_addr_q[XLEN-1:2];
            D_writeData = hold_wdata_q;
            D_byteEn    = hold_be_q;
        end else if (done_q) begin
            D_addr      = hold_addr_q[XLEN-1:2];
            D_writeData = '0;
            D_byteEn    = '0;
        end else begin
            D_ren = req3 & is_ld3;
            D_wen = req3 & is_st3;
        end
    end

    assign mem_busy = busy;

    logic [XLEN-1:0] src_addr, src_raw, ld_ext;
    logic [1:0]      src_off, src_mem;
    logic [2:0]      src_f3;
    logic [4:0]      src_rd;
    logic            src_wb, src_mis;

    always_comb begin : stage4_src
        if (use_hold) begin
            src_addr = hold_addr_q;
            src_raw  = done_q ? hold_rdata_q : D_readData;
            src_off  = hold_off_q;
            src_mem  = hold_mem_q;
            src_f3   = hold_f3_q;
            src_rd   = hold_rd_q;
            src_wb   = hold_wb_q;
            src_mis  = 1'b0;
        end else begin
            src_addr = ALU_result_3;
            src_raw  = D_readData;
            src_off  = off3;
            src_mem  = mem3;
            src_f3   = Funct3_3;
            src_rd   = Rd_3;
            src_wb   = WriteBack_3;
            src_mis  = mis3;
        end
    end

    load_align #(
        .XLEN      (XLEN),
        .BYTE_SWAP (BYTE_SWAP)
    ) u_load_align (
        .raw_data (src_raw),
        .off      (src_off),
        .funct3   (src_f3),
        .ld_data  (ld_ext)
    );

    always_comb begin : next_state
        state_d      = state_q;
        done_d       = done_q;
        hold_addr_d  = hold_addr_q;
        hold_wdata_d = hold_wdata_q;
        hold_rdata_d = hold_rdata_q;
        hold_be_d    = hold_be_q;
        hold_f3_d    = hold_f3_q;
        hold_rd_d    = hold_rd_q;
        hold_wb_d    = hold_wb_q;
        hold_mem_d   = hold_mem_q;
        hold_off_d   = hold_off_q;
        res_d        = res_q;
        alu4_d       = alu4_q;
        rd4_d        = rd4_q;
        wb4_d        = wb4_q;
        m2r_d        = m2r_q;
`ifdef MISALIGN_TRAP_EN
        mis4_d       = mis4_q;
`endif

        if (in_wait) state_d = D_ready ? ST_IDLE : ST_WAIT;
        else         state_d = (req3 & ~D_ready) ? ST_WAIT : ST_IDLE;

        if (req3 & (~D_ready | memory_stall)) begin
            hold_addr_d  = ALU_result_3;
            hold_wdata_d = wd3;
            hold_be_d    = be3;
            hold_f3_d    = Funct3_3;
            hold_rd_d    = Rd_3;
            hold_wb_d    = WriteBack_3;
            hold_mem_d   = mem3;
            hold_off_d   = off3;
        end

        if (complete & memory_stall) begin
            hold_rdata_d = D_readData;
            done_d       = 1'b1;
        end else if (done_q & ~memory_stall) begin
            done_d = 1'b0;
        end

        if (adv) begin
            res_d  = ld_ext;
            alu4_d = src_addr;
            rd4_d  = src_rd;
            wb4_d  = src_wb & ~src_mis;
            m2r_d  = src_mem[MEM_LD] & ~src_mis;
`ifdef MISALIGN_TRAP_EN
            mis4_d = src_mis;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            done_q       <= 1'b0;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
            hold_rdata_q <= '0;
            hold_be_q    <= '0;
            hold_f3_q    <= '0;
            hold_rd_q    <= '0;
            hold_wb_q    <= 1'b0;
            hold_mem_q   <= '0;
            hold_off_q   <= '0;
            res_q        <= '0;
            alu4_q       <= '0;
            rd4_q        <= '0;
            wb4_q        <= 1'b0;
            m2r_q        <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            mis4_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            done_q       <= done_d;
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
            hold_rdata_q <= hold_rdata_d;
            hold_be_q    <= hold_be_d;
            hold_f3_q    <= hold_f3_d;
            hold_rd_q    <= hold_rd_d;
            hold_wb_q    <= hold_wb_d;
            hold_mem_q   <= hold_mem_d;
            hold_off_q   <= hold_off_d;
            res_q        <= res_d;
            alu4_q       <= alu4_d;
            rd4_q        <= rd4_d;
            wb4_q        <= wb4_d;
            m2r_q        <= m2r_d;
`ifdef MISALIGN_TRAP_EN
            mis4_q       <= mis4_d;
`endif
        end
    end

    assign memory_result_4 = res_q;
    assign ALU_result_4    = alu4_q;
    assign Rd_4            = rd4_q;
    assign WriteBack_4     = wb4_q;
    assign Mem2Reg         = m2r_q;
`ifdef MISALIGN_TRAP_EN
    assign misalign_4      = mis4_q;
`endif

endmodule

// File: tb/tb_mem_stage_be.sv
// Directed bench for mem_stage_be (XLEN=32, BYTE_SWAP=1): vector table for
// zero-wait accesses plus sequences for wait states, freeze, reset and misalign.
module tb_mem_stage_be;

    logic        clk = 1'b0;
    logic        rst_n, memory_stall, WriteBack_3, D_ready;
    logic [31:0] ALU_result_3, writedata_3, D_readData;
    logic [1:0]  Mem_3;
    logic [2:0]  Funct3_3;
    logic [4:0]  Rd_3;
    logic [29:0] D_addr;
    logic        D_ren, D_wen, mem_busy, WriteBack_4, Mem2Reg;
    logic [31:0] D_writeData, memory_result_4, ALU_result_4;
    logic [3:0]  D_byteEn;
    logic [4:0]  Rd_4;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_4;
`endif

    mem_stage_be #(.XLEN(32), .BYTE_SWAP(1)) dut (
        .clk(clk), .rst_n(rst_n), .memory_stall(memory_stall),
        .ALU_result_3(ALU_result_3), .writedata_3(writedata_3),
        .WriteBack_3(WriteBack_3), .Mem_3(Mem_3), .Funct3_3(Funct3_3),
        .Rd_3(Rd_3), .D_readData(D_readData), .D_ready(D_ready),
        .D_addr(D_addr), .D_ren(D_ren), .D_wen(D_wen),
        .D_writeData(D_writeData), .D_byteEn(D_byteEn), .mem_busy(mem_busy),
        .memory_result_4(memory_result_4), .ALU_result_4(ALU_result_4),
        .Rd_4(Rd_4), .WriteBack_4(WriteBack_4), .Mem2Reg(Mem2Reg)
`ifdef MISALIGN_TRAP_EN
        , .misalign_4(misalign_4)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        memory_stall = 1'b0;
        ALU_result_3 = 32'h0;
        writedata_3  = 32'h0;
        WriteBack_3  = 1'b0;
        Mem_3        = 2'b00;
        Funct3_3     = 3'b010;
        Rd_3         = 5'd0;
        D_readData   = 32'h0;
        D_ready      = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  mem;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, rdata, e_addr;
        logic        e_ren, e_wen;
        logic [3:0]  e_be;
        logic [31:0] e_wd, e_res;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] m, input logic [2:0] f,
                                input logic [31:0] a, input logic [31:0] w,
                                input logic [31:0] r, input logic [31:0] ea,
                                input logic er, input logic ew, input logic [3:0] eb,
                                input logic [31:0] ewd, input logic [31:0] eres);
        vec_t v;
        v.mem = m; v.f3 = f; v.addr = a; v.wdata = w; v.rdata = r; v.e_addr = ea;
        v.e_ren = er; v.e_wen = ew; v.e_be = eb; v.e_wd = ewd; v.e_res = eres;
        return v;
    endfunction

    vec_t vt[12];
    int   busy_cnt;
    logic got;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vt[0]  = mk(2'b10, 3'b010, 32'h100, 32'h0,        32'h78563412, 32'h40, 1'b1, 1'b0, 4'hF, 32'h0,        32'h12345678);
        vt[1]  = mk(2'b10, 3'b000, 32'h103, 32'h0,        32'h00000080, 32'h40, 1'b1, 1'b0, 4'h1, 32'h0,        32'hFFFFFF80);
        vt[2]  = mk(2'b10, 3'b100, 32'h103, 32'h0,        32'h00000080, 32'h40, 1'b1, 1'b0, 4'h1, 32'h0,        32'h00000080);
        vt[3]  = mk(2'b10, 3'b001, 32'h102, 32'h0,        32'h00000180, 32'h40, 1'b1, 1'b0, 4'h3, 32'h0,        32'hFFFF8001);
        vt[4]  = mk(2'b10, 3'b101, 32'h102, 32'h0,        32'h00000180, 32'h40, 1'b1, 1'b0, 4'h3, 32'h0,        32'h00008001);
        vt[5]  = mk(2'b10, 3'b001, 32'h100, 32'h0,        32'h3412ABCD, 32'h40, 1'b1, 1'b0, 4'hC, 32'h0,        32'h00001234);
        vt[6]  = mk(2'b10, 3'b000, 32'h200, 32'h0,        32'h7F000000, 32'h80, 1'b1, 1'b0, 4'h8, 32'h0,        32'h0000007F);
        vt[7]  = mk(2'b01, 3'b001, 32'h202, 32'h1234BEEF, 32'h0,        32'h80, 1'b0, 1'b1, 4'h3, 32'hEFBEEFBE, 32'h0);
        vt[8]  = mk(2'b01, 3'b000, 32'h301, 32'hFFFFFFA5, 32'h0,        32'hC0, 1'b0, 1'b1, 4'h4, 32'hA5A5A5A5, 32'h0);
        vt[9]  = mk(2'b01, 3'b010, 32'h304, 32'h11223344, 32'h0,        32'hC1, 1'b0, 1'b1, 4'hF, 32'h44332211, 32'h0);
        vt[10] = mk(2'b00, 3'b010, 32'h055, 32'hAAAA5555, 32'h0,        32'h15, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0);
        vt[11] = mk(2'b11, 3'b000, 32'h3FC, 32'h1,        32'h0,        32'hFF, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0);

        // reset state
        rst_n = 1'b0;
        idle_inputs();
        step();
        step();
        chk("rst_res",  memory_result_4, 32'h0);
        chk("rst_alu4", ALU_result_4, 32'h0);
        chk("rst_rd4",  32'(Rd_4), 32'h0);
        chk("rst_wb4",  32'(WriteBack_4), 32'h0);
        chk("rst_m2r",  32'(Mem2Reg), 32'h0);
        chk("rst_ren",  32'(D_ren), 32'h0);
        chk("rst_busy", 32'(mem_busy), 32'h0);
`ifdef MISALIGN_TRAP_EN
        chk("rst_mis4", 32'(misalign_4), 32'h0);
`endif
        rst_n = 1'b1;
        step();

        // zero-wait accesses
        for (int i = 0; i < 12; i++) begin
            Mem_3        = vt[i].mem;
            Funct3_3     = vt[i].f3;
            ALU_result_3 = vt[i].addr;
            writedata_3  = vt[i].wdata;
            D_readData   = vt[i].rdata;
            WriteBack_3  = (vt[i].mem == 2'b10);
            Rd_3         = 5'(i + 1);
            D_ready      = 1'b1;
            #1;
            chk($sformatf("v%0d_addr", i), 32'(D_addr), vt[i].e_addr);
            chk($sformatf("v%0d_ren", i),  32'(D_ren), 32'(vt[i].e_ren));
            chk($sformatf("v%0d_wen", i),  32'(D_wen), 32'(vt[i].e_wen));
            chk($sformatf("v%0d_be", i),   32'(D_byteEn), 32'(vt[i].e_be));
            chk($sformatf("v%0d_wd", i),   D_writeData, vt[i].e_wd);
            chk($sformatf("v%0d_busy", i), 32'(mem_busy), 32'h0);
            step();
            chk($sformatf("v%0d_res", i),  memory_result_4, vt[i].e_res);
            chk($sformatf("v%0d_alu4", i), ALU_result_4, vt[i].addr);
            chk($sformatf("v%0d_rd4", i),  32'(Rd_4), 32'(i + 1));
            chk($sformatf("v%0d_wb4", i),  32'(WriteBack_4), 32'(vt[i].mem == 2'b10));
            chk($sformatf("v%0d_m2r", i),  32'(Mem2Reg), 32'(vt[i].mem == 2'b10));
        end

        // LB at 0x103 acknowledged on the fourth request cycle
        idle_inputs();
        Mem_3 = 2'b10; Funct3_3 = 3'b000; ALU_result_3 = 32'h103; WriteBack_3 = 1'b1; Rd_3 = 5'd7;
        busy_cnt = 0;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            D_ready    = (c == 3);
            D_readData = (c == 3) ? 32'h00000080 : 32'h0;
            #1;
            if (mem_busy) busy_cnt++;
            chk($sformatf("lbw_ren%0d", c), 32'(D_ren), 32'h1);
            chk($sformatf("lbw_addr%0d", c), 32'(D_addr), 32'h40);
            if (D_ready) got = 1'b1;
            step();
        end
        chk("lbw_busy_cycles", 32'(busy_cnt), 32'd3);
        chk("lbw_res", memory_result_4, 32'hFFFFFF80);
        chk("lbw_rd4", 32'(Rd_4), 32'd7);
        chk("lbw_wb4", 32'(WriteBack_4), 32'h1);

        idle_inputs();
        step();
        chk("idle_res", memory_result_4, 32'h0);

        // freeze across completion while in WAIT
        Mem_3 = 2'b10; Funct3_3 = 3'b010; ALU_result_3 = 32'h100; WriteBack_3 = 1'b1; Rd_3 = 5'd9;
        #1;
        chk("frz_busy0", 32'(mem_busy), 32'h1);
        step();
        ALU_result_3 = 32'hFFF0; Mem_3 = 2'b00; Rd_3 = 5'd3;
        #1;
        chk("frz_addr1", 32'(D_addr), 32'h40);
        chk("frz_ren1",  32'(D_ren), 32'h1);
        step();
        memory_stall = 1'b1; D_ready = 1'b1; D_readData = 32'h78563412;
        #1;
        chk("frz_addr2", 32'(D_addr), 32'h40);
        chk("frz_busy2", 32'(mem_busy), 32'h0);
        step();
        D_ready = 1'b0; D_readData = 32'hDEADBEEF;
        #1;
        chk("frz_ren3",  32'(D_ren), 32'h0);
        chk("frz_addr3", 32'(D_addr), 32'h40);
        step();
        chk("frz_hold_res", memory_result_4, 32'h0);
        chk("frz_hold_rd4", 32'(Rd_4), 32'h0);
        memory_stall = 1'b0;
        step();
        chk("frz_res",  memory_result_4, 32'h12345678);
        chk("frz_alu4", ALU_result_4, 32'h100);
        chk("frz_rd4",  32'(Rd_4), 32'd9);
        idle_inputs();
        step();

        // SH with one wait state
        Mem_3 = 2'b01; Funct3_3 = 3'b001; ALU_result_3 = 32'h202; writedata_3 = 32'h0000BEEF;
        #1;
        chk("shw_wen0", 32'(D_wen), 32'h1);
        chk("shw_be0",  32'(D_byteEn), 32'h3);
        chk("shw_wd0",  D_writeData, 32'hEFBEEFBE);
        step();
        D_ready = 1'b1; writedata_3 = 32'h0;
        #1;
        chk("shw_wen1", 32'(D_wen), 32'h1);
        chk("shw_wd1",  D_writeData, 32'hEFBEEFBE);
        step();
        idle_inputs();
        #1;
        chk("shw_wen2", 32'(D_wen), 32'h0);
        chk("shw_be2",  32'(D_byteEn), 32'h0);
        step();

        // reset while waiting
        Mem_3 = 2'b10; Funct3_3 = 3'b010; ALU_result_3 = 32'h100; WriteBack_3 = 1'b1; Rd_3 = 5'd5;
        D_ready = 1'b1; D_readData = 32'h78563412;
        step();
        D_ready = 1'b0;
        step();
        chk("rsw_ren_wait", 32'(D_ren), 32'h1);
        rst_n = 1'b0;
        idle_inputs();
        step();
        chk("rsw_ren",  32'(D_ren), 32'h0);
        chk("rsw_wen",  32'(D_wen), 32'h0);
        chk("rsw_busy", 32'(mem_busy), 32'h0);
        chk("rsw_addr", 32'(D_addr), 32'h0);
        chk("rsw_res",  memory_result_4, 32'h0);
        chk("rsw_alu4", ALU_result_4, 32'h0);
        chk("rsw_rd4",  32'(Rd_4), 32'h0);
        chk("rsw_wb4",  32'(WriteBack_4), 32'h0);
        chk("rsw_m2r",  32'(Mem2Reg), 32'h0);
        rst_n = 1'b1;
        step();
        #1;
        chk("rsw_idle_ren", 32'(D_ren), 32'h0);

        // LW at 0x101
        Mem_3 = 2'b10; Funct3_3 = 3'b010; ALU_result_3 = 32'h101; WriteBack_3 = 1'b1; Rd_3 = 5'd4;
`ifdef MISALIGN_TRAP_EN
        D_ready = 1'b0;
        #1;
        chk("mis_ren",  32'(D_ren), 32'h0);
        chk("mis_busy", 32'(mem_busy), 32'h0);
        step();
        chk("mis_flag", 32'(misalign_4), 32'h1);
        chk("mis_wb4",  32'(WriteBack_4), 32'h0);
        chk("mis_m2r",  32'(Mem2Reg), 32'h0);
`else
        D_ready = 1'b1; D_readData = 32'h78563412;
        #1;
        chk("mis_addr", 32'(D_addr), 32'h40);
        chk("mis_ren",  32'(D_ren), 32'h1);
        chk("mis_busy", 32'(mem_busy), 32'h0);
        step();
        chk("mis_res",  memory_result_4, 32'h12345678);
        chk("mis_wb4",  32'(WriteBack_4), 32'h1);
        chk("mis_m2r",  32'(Mem2Reg), 32'h1);
`endif
        idle_inputs();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
